// File: rtl/fetch_sequencer_if.sv
// -----------------------------------------------------------------------------
// fetch_sequencer_if
//
// Bundles the fetch-stage signals between instruction memory, the data-memory
// stall source, the decode stage and the PC apparatus.
//
// Signals:
//   iMemIn       raw word from instruction memory at the current PC
//   memStall     data-memory busy; freezes fetch while high
//   instruction  word issued to decode
//   pcWrtEn      PC register write enable
//   pcSel        PC source select (PC+4 / PC+offset / reg+offset)
//   bubble       high when instruction is the inserted bubble word
//   illegalOp    fetched opcode is outside the supported opcode set
//   bubbleCount  saturating bubble counter (only with FETCH_PERF_CNT_EN)
//
// Modports:
//   master  the fetch sequencer itself
//   slave   the surrounding pipeline (memory, decode, PC apparatus)
//
// Build option: FETCH_PERF_CNT_EN adds bubbleCount.
// -----------------------------------------------------------------------------
interface fetch_sequencer_if #(
  parameter int unsigned DBITS = 32
);
  logic [DBITS-1:0] iMemIn;
  logic             memStall;
  logic [DBITS-1:0] instruction;
  logic             pcWrtEn;
  logic [1:0]       pcSel;
  logic             bubble;
  logic             illegalOp;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0]      bubbleCount;
`endif

  modport master (
    input  iMemIn,
    input  memStall,
    output instruction,
    output pcWrtEn,
    output pcSel,
    output bubble,
`ifdef FETCH_PERF_CNT_EN
    output bubbleCount,
`endif
    output illegalOp
  );

  modport slave (
    output iMemIn,
    output memStall,
    input  instruction,
    input  pcWrtEn,
    input  pcSel,
    input  bubble,
`ifdef FETCH_PERF_CNT_EN
    input  bubbleCount,
`endif
    input  illegalOp
  );
endinterface

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//
// Fetch-stage control sequencer. Classifies each fetched word, passes it to
// decode or replaces it with a bubble, and drives the PC write enable and PC
// source select. A BRANCH/JAL is issued once and then held for BRANCH_WAIT
// bubble cycles so execute can resolve it; the PC is written on the last
// bubble. A data-memory stall freezes the whole sequence.
//
// Parameters:
//   DBITS        instruction width
//   BRANCH_WAIT  bubble cycles after a control word before the PC loads (1..15)
//   NOOP_WORD    bubble instruction word
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low; forces bubble outputs while low
//   bus    fetch_sequencer_if.master (iMemIn, memStall in; instruction,
//          pcWrtEn, pcSel, bubble, illegalOp [, bubbleCount] out)
//
// Build option: FETCH_PERF_CNT_EN adds the saturating bubbleCount output.
// -----------------------------------------------------------------------------
module fetch_sequencer #(
  parameter int unsigned      DBITS       = 32,
  parameter int unsigned      BRANCH_WAIT = 2,
  parameter logic [DBITS-1:0] NOOP_WORD   = 32'h3b000099
) (
  input logic              clk,
  input logic              reset,
  fetch_sequencer_if.master bus
);

  // Opcode encoding of iMemIn[27:24], matching the decoder.
  localparam logic [3:0] OP_ALUR   = 4'h0;
  localparam logic [3:0] OP_CMPR   = 4'h2;
  localparam logic [3:0] OP_STORE  = 4'h5;
  localparam logic [3:0] OP_BRANCH = 4'h6;
  localparam logic [3:0] OP_ALUI   = 4'h8;
  localparam logic [3:0] OP_LOAD   = 4'h9;
  localparam logic [3:0] OP_CMPI   = 4'hA;
  localparam logic [3:0] OP_JAL    = 4'hB;

  // PC source select encoding shared with the PC apparatus.
  localparam logic [1:0] PCSEL_PCPLUSFOUR = 2'd0;
  localparam logic [1:0] PCSEL_PCOFFSET   = 2'd1;
  localparam logic [1:0] PCSEL_REGOFFSET  = 2'd2;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  localparam logic KIND_BRANCH = 1'b0;
  localparam logic KIND_JAL    = 1'b1;

  // Counter value on the final bubble of the resolve window.
  localparam logic [3:0] WAIT_LAST = 4'(BRANCH_WAIT);

  if (BRANCH_WAIT < 1 || BRANCH_WAIT > 15) begin : g_bad_wait
    $error("fetch_sequencer: BRANCH_WAIT must be in 1..15");
  end

  logic [0:0] state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       ctl_kind, ctl_kind_nxt;

  logic [3:0] opcode;
  logic       is_straight;
  logic       is_ctl;

  always_comb begin
    opcode      = bus.iMemIn[27:24];
    is_straight = (opcode == OP_ALUR)  || (opcode == OP_ALUI) ||
                  (opcode == OP_CMPR)  || (opcode == OP_CMPI) ||
                  (opcode == OP_LOAD)  || (opcode == OP_STORE);
    is_ctl      = (opcode == OP_BRANCH) || (opcode == OP_JAL);
  end

  // NOTE: every output and next-state signal gets a default before the case
  // so no path leaves one unassigned, which would infer a latch.
  always_comb begin
    bus.instruction = NOOP_WORD;
    bus.bubble      = 1'b1;
    bus.pcWrtEn     = 1'b0;
    bus.pcSel       = PCSEL_PCPLUSFOUR;
    bus.illegalOp   = 1'b0;
    state_nxt       = state;
    cnt_nxt         = cnt;
    ctl_kind_nxt    = ctl_kind;

    // While reset is low the defaults above are the forced bubble outputs.
    if (reset) begin
      case (state)
        ST_RUN: begin
          // Illegal opcodes flow as straight-line words, flagged.
          bus.illegalOp = !is_straight && !is_ctl;
          if (!bus.memStall) begin
            bus.instruction = bus.iMemIn;
            bus.bubble      = 1'b0;
            if (is_ctl) begin
              // The PC holds on the control word until the window closes.
              ctl_kind_nxt = (opcode == OP_JAL) ? KIND_JAL : KIND_BRANCH;
              cnt_nxt      = 4'd1;
              state_nxt    = ST_WAIT;
            end else begin
              bus.pcWrtEn = 1'b1;
            end
          end
        end

        ST_WAIT: begin
          // iMemIn still shows the held control word; it is not re-examined.
          bus.pcSel = (ctl_kind == KIND_JAL) ? PCSEL_REGOFFSET : PCSEL_PCOFFSET;
          if (!bus.memStall) begin
            if (cnt == WAIT_LAST) begin
              bus.pcWrtEn = 1'b1;
              cnt_nxt     = 4'd0;
              state_nxt   = ST_RUN;
            end else begin
              cnt_nxt = cnt + 4'd1;
            end
          end
        end

        default: begin
          state_nxt = ST_RUN;
          cnt_nxt   = 4'd0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_RUN;
      cnt      <= 4'd0;
      ctl_kind <= KIND_BRANCH;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      ctl_kind <= ctl_kind_nxt;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] bubble_count;

  // Counts every out-of-reset edge on which a bubble was issued; saturates.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bubble_count <= 16'd0;
    end else if (bus.bubble && (bubble_count != 16'hFFFF)) begin
      bubble_count <= bubble_count + 16'd1;
    end
  end

  assign bus.bubbleCount = bubble_count;
`endif

endmodule
